// File: rtl/snow64_seq_normalizer_pkg.sv
// Shared types and width helpers for the sequential normalizer.
package snow64_seq_normalizer_pkg;

  typedef enum logic [1:0] {
    INT_SIZE_8  = 2'd0,
    INT_SIZE_16 = 2'd1,
    INT_SIZE_32 = 2'd2,
    INT_SIZE_64 = 2'd3
  } int_type_size_e;

  typedef enum logic [1:0] {
    NORM_IDLE  = 2'd0,
    NORM_SHIFT = 2'd1,
    NORM_DONE  = 2'd2
  } norm_state_e;

  localparam logic [6:0] WIDTH_8  = 7'd8;
  localparam logic [6:0] WIDTH_16 = 7'd16;
  localparam logic [6:0] WIDTH_32 = 7'd32;
  localparam logic [6:0] WIDTH_64 = 7'd64;

  localparam logic [5:0] MSB_POS_8  = 6'd7;
  localparam logic [5:0] MSB_POS_16 = 6'd15;
  localparam logic [5:0] MSB_POS_32 = 6'd31;
  localparam logic [5:0] MSB_POS_64 = 6'd63;

  function automatic logic [6:0] width_of(int_type_size_e size);
    case (size)
      INT_SIZE_8:  width_of = WIDTH_8;
      INT_SIZE_16: width_of = WIDTH_16;
      INT_SIZE_32: width_of = WIDTH_32;
      default:     width_of = WIDTH_64;
    endcase
  endfunction

  function automatic logic [5:0] msb_pos_of(int_type_size_e size);
    case (size)
      INT_SIZE_8:  msb_pos_of = MSB_POS_8;
      INT_SIZE_16: msb_pos_of = MSB_POS_16;
      INT_SIZE_32: msb_pos_of = MSB_POS_32;
      default:     msb_pos_of = MSB_POS_64;
    endcase
  endfunction

  // First binary-search step is half the operand width.
  function automatic logic [5:0] first_step_of(int_type_size_e size);
    first_step_of = (msb_pos_of(size) >> 1) + 6'd1;
  endfunction

  // Ones in bits [W-1:0], zeros above.
  function automatic logic [63:0] mask_of(int_type_size_e size);
    mask_of = {64{1'b1}} >> (7'd64 - width_of(size));
  endfunction

endpackage

// File: rtl/snow64_seq_normalizer_step.sv
// One binary-search stage of the normalizer (combinational).
module snow64_seq_normalizer_step
  import snow64_seq_normalizer_pkg::*;
(
  input  logic [63:0]    value_i,
  input  logic [6:0]     count_i,
  input  logic [5:0]     step_i,
  input  int_type_size_e size_i,
  input  logic           signed_i,
  output logic [63:0]    value_o,
  output logic [6:0]     count_o
);

  logic [63:0] aligned;
  logic [63:0] diff;
  logic [63:0] hi_mask;
  logic        hit;

  // Left-align the W-bit value so one top-of-word mask serves every width;
  // in signed mode diff bit i flags a[i] != a[i-1], so `step` clear diff bits
  // at the top mean `step+1` equal sign bits.
  always_comb begin
    aligned = value_i << (7'd64 - width_of(size_i));
    diff    = aligned ^ (aligned << 1);
    hi_mask = ~({64{1'b1}} >> step_i);
    hit     = signed_i ? ((diff & hi_mask) == 64'd0)
                       : ((aligned & hi_mask) == 64'd0);
    value_o = hit ? ((value_i << step_i) & mask_of(size_i)) : value_i;
    count_o = hit ? (count_i + {1'b0, step_i}) : count_i;
  end

endmodule

// File: rtl/snow64_seq_normalizer.sv
// Multi-cycle normalizer: recovers the normalizing left-shift amount of an
// 8/16/32/64-bit operand, one binary-search stage per clock.
module snow64_seq_normalizer
  import snow64_seq_normalizer_pkg::*;
(
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_valid,
  output logic        out_in_ready,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_int_type_size,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        in_out_ready,
  output logic [63:0] out_data,
  output logic [6:0]  out_count,
  output logic        out_is_zero
);

  norm_state_e    state_q;
  int_type_size_e size_q;
  logic           signed_q;
  logic [63:0]    value_q;
  logic [6:0]     count_q;
  logic [5:0]     step_q;
  logic           ready_q;
  logic           valid_q;
  logic           zero_q;

  int_type_size_e size_in;
  logic [63:0]    masked_in;
  logic [63:0]    value_d;
  logic [6:0]     count_d;

  assign size_in   = int_type_size_e'(in_int_type_size);
  assign masked_in = in_data & mask_of(size_in);

  snow64_seq_normalizer_step u_step (
    .value_i  (value_q),
    .count_i  (count_q),
    .step_i   (step_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .value_o  (value_d),
    .count_o  (count_d)
  );

  // Handshake FSM; all outputs come straight from registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= NORM_IDLE;
      size_q   <= INT_SIZE_8;
      signed_q <= 1'b0;
      value_q  <= 64'd0;
      count_q  <= 7'd0;
      step_q   <= 6'd0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        NORM_IDLE: begin
          if (in_valid) begin
            size_q   <= size_in;
            signed_q <= in_signed;
            ready_q  <= 1'b0;
            step_q   <= first_step_of(size_in);
            if (masked_in == 64'd0) begin
              value_q <= 64'd0;
              count_q <= in_signed ? (width_of(size_in) - 7'd1) : width_of(size_in);
              zero_q  <= 1'b1;
              valid_q <= 1'b1;
              state_q <= NORM_DONE;
            end else begin
              value_q <= masked_in;
              count_q <= 7'd0;
              zero_q  <= 1'b0;
              state_q <= NORM_SHIFT;
            end
          end
        end
        NORM_SHIFT: begin
          value_q <= value_d;
          count_q <= count_d;
          step_q  <= step_q >> 1;
          if (step_q == 6'd1) begin
            valid_q <= 1'b1;
            state_q <= NORM_DONE;
          end
        end
        NORM_DONE: begin
          if (in_out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= NORM_IDLE;
          end
        end
        default: begin
          state_q <= NORM_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_in_ready = ready_q;
  assign out_valid    = valid_q;
  assign out_data     = value_q;
  assign out_count    = count_q;
  assign out_is_zero  = zero_q;

endmodule

// File: tb/tb_snow64_seq_normalizer.sv
// Self-checking bench for snow64_seq_normalizer.
module tb_snow64_seq_normalizer;

  logic        in_clk;
  logic        in_rst_n;
  logic        in_valid;
  logic        out_in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_int_type_size;
  logic        in_signed;
  logic        out_valid;
  logic        in_out_ready;
  logic [63:0] out_data;
  logic [6:0]  out_count;
  logic        out_is_zero;

  int n_cmp = 0;
  int n_err = 0;

  snow64_seq_normalizer dut (
    .in_clk           (in_clk),
    .in_rst_n         (in_rst_n),
    .in_valid         (in_valid),
    .out_in_ready     (out_in_ready),
    .in_data          (in_data),
    .in_int_type_size (in_int_type_size),
    .in_signed        (in_signed),
    .out_valid        (out_valid),
    .in_out_ready     (in_out_ready),
    .out_data         (out_data),
    .out_count        (out_count),
    .out_is_zero      (out_is_zero)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk bits from the MSB down, count zeros (unsigned) or copies
  // of the sign bit (signed), then shift by that count.
  task automatic model(input logic [63:0] d, input logic [1:0] sz, input logic sg,
                       output logic [63:0] od, output logic [6:0] oc,
                       output logic oz, output int lat);
    int w;
    int n;
    bit stop;
    logic [63:0] mask;
    logic [63:0] m;
    w    = 8 << sz;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    m    = d & mask;
    n    = 0;
    stop = 0;
    if (m == 64'd0) begin
      oz  = 1'b1;
      oc  = sg ? 7'(w - 1) : 7'(w);
      od  = 64'd0;
      lat = 0;
    end else begin
      if (!sg) begin
        for (int i = w - 1; i >= 0; i--)
          if (!stop) begin
            if (m[i]) stop = 1;
            else n++;
          end
      end else begin
        for (int i = w - 2; i >= 0; i--)
          if (!stop) begin
            if (m[i] == m[w-1]) n++;
            else stop = 1;
          end
      end
      oz  = 1'b0;
      oc  = 7'(n);
      od  = (m << n) & mask;
      lat = $clog2(w);
    end
  endtask

  task automatic start_op(input logic [63:0] d, input logic [1:0] sz, input logic sg);
    check("ready_before_accept", 64'(out_in_ready), 64'd1);
    in_data          = d;
    in_int_type_size = sz;
    in_signed        = sg;
    in_valid         = 1'b1;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_int_type_size = 2'($urandom_range(0, 3));
    in_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input string tag, input logic [63:0] ed, input logic [6:0] ec,
                             input logic ez, input int elat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge in_clk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_data"}, out_data, ed);
    check({tag, "_count"}, 64'(out_count), 64'(ec));
    check({tag, "_is_zero"}, 64'(out_is_zero), 64'(ez));
    check({tag, "_in_ready_busy"}, 64'(out_in_ready), 64'd0);
  endtask

  task automatic handshake(input string tag);
    in_out_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(out_in_ready), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [63:0] d, input logic [1:0] sz,
                       input logic sg, input logic [63:0] ed, input logic [6:0] ec,
                       input logic ez, input int elat);
    start_op(d, sz, sg);
    wait_result(tag, ed, ec, ez, elat);
    handshake(tag);
  endtask

  task automatic do_rand_op(input string tag, input logic [63:0] d, input logic [1:0] sz,
                            input logic sg);
    logic [63:0] ed;
    logic [6:0]  ec;
    logic        ez;
    int          elat;
    model(d, sz, sg, ed, ec, ez, elat);
    do_op(tag, d, sz, sg, ed, ec, ez, elat);
  endtask

  initial begin
    logic [63:0] rd;
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 64'd0;
    in_int_type_size = 2'd0;
    in_signed = 1'b0;
    in_out_ready = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    check("rst_in_ready", 64'(out_in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_is_zero", 64'(out_is_zero), 64'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    @(posedge in_clk);
    #1;

    // Directed operations with constant expectations.
    do_op("w8_u_01", 64'h01, 2'd0, 1'b0, 64'h80, 7'd7, 1'b0, 3);
    do_op("w64_u_10000", 64'h0000_0000_0001_0000, 2'd3, 1'b0,
          64'h8000_0000_0000_0000, 7'd47, 1'b0, 6);
    do_op("w32_u_masked0", 64'hFFFF_FFFF_0000_0000, 2'd2, 1'b0, 64'd0, 7'd32, 1'b1, 0);
    do_op("w16_s_fff0", 64'hFFF0, 2'd1, 1'b1, 64'h8000, 7'd11, 1'b0, 4);
    do_op("w16_s_7fff", 64'h7FFF, 2'd1, 1'b1, 64'h7FFF, 7'd0, 1'b0, 4);
    do_op("w8_s_zero", 64'hFF00, 2'd0, 1'b1, 64'd0, 7'd7, 1'b1, 0);
    do_op("w32_s_ones", 64'h0000_0000_FFFF_FFFF, 2'd2, 1'b1, 64'h8000_0000, 7'd31, 1'b0, 5);
    do_op("w64_u_msb", 64'h8000_0000_0000_0000, 2'd3, 1'b0,
          64'h8000_0000_0000_0000, 7'd0, 1'b0, 6);

    // Back-pressure: result held in DONE while in_valid is pulsed.
    start_op(64'h10, 2'd0, 1'b0);
    wait_result("bp", 64'h80, 7'd3, 1'b0, 3);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'(k % 2 == 0);
      in_data  = 64'h1;
      in_int_type_size = 2'd3;
      @(posedge in_clk);
      #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(out_in_ready), 64'd0);
      check("bp_hold_data", out_data, 64'h80);
      check("bp_hold_count", 64'(out_count), 64'd3);
    end
    in_valid = 1'b0;
    handshake("bp");

    // Reset in the second SHIFT cycle of a 64-bit op.
    start_op(64'h1, 2'd3, 1'b0);
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(out_in_ready), 64'd1);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", out_data, 64'd0);
    check("midrst_count", 64'(out_count), 64'd0);
    check("midrst_is_zero", 64'(out_is_zero), 64'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    @(posedge in_clk);
    #1;
    do_op("after_rst_w8_3", 64'h3, 2'd0, 1'b0, 64'hC0, 7'd6, 1'b0, 3);

    // Randomized operations against the reference model.
    for (int t = 0; t < 60; t++) begin
      rd = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) rd = ~rd;
      if ($urandom_range(0, 9) == 0) rd = 64'd0;
      do_rand_op("rand", rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
